alu4_sequencer: RTL and testbench
=================================

# alu4_sequencer

Command-driven operand sequencer that sits directly upstream of the 4-bit combinational ALU. It accepts one command at a time over a valid/ready handshake and holds a small register file. It drives the ALU's option and operand inputs from registered values, captures the ALU result back into the register file, and reports each completed result with a one-cycle strobe. The ALU's opcode encoding passes through unchanged; this block adds no new operations.

## Interface
Parameters:
- WIDTH, 4: data width; must equal the ALU operand width.
- ADDR_W, 2: register-file address width; 2**ADDR_W registers.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command this cycle.
- cmd_op  in  3  ALU opcode, forwarded to ALU_option.
- cmd_dst  in  ADDR_W  destination register.
- cmd_src1  in  ADDR_W  first operand register.
- cmd_src2  in  ADDR_W  second operand register.
- cmd_imm  in  WIDTH  immediate value.
- cmd_use_imm  in  1  second operand is cmd_imm instead of rf[cmd_src2].
- cmd_load  in  1  write cmd_imm to rf[cmd_dst] without using the ALU.
- ALU_option  out  3  registered opcode to the ALU.
- ALU_in1  out  WIDTH  registered operand 1 to the ALU.
- ALU_in2  out  WIDTH  registered operand 2 to the ALU.
- ALU_out  in  WIDTH  combinational ALU result.
- res_valid  out  1  one-cycle strobe: a result was written.
- res_data  out  WIDTH  value written.
- res_dst  out  ADDR_W  register written.
- res_zero  out  1  res_data == 0.
- rd_addr  in  ADDR_W  debug read address.
- rd_data  out  WIDTH  combinational rf[rd_addr].

## Operation
- FSM states:
  - IDLE: cmd_ready = 1, except while reset is high.
  - EXEC: cmd_ready = 0.
- A command is accepted on a rising edge where cmd_valid && cmd_ready.
- Accept with cmd_load = 1:
  - rf[cmd_dst] <= cmd_imm, and res_data/res_dst are updated at the same edge.
  - res_valid = 1 in the next cycle.
  - FSM stays in IDLE; cmd_op, src fields and cmd_use_imm are ignored.
  - ALU_* outputs are unchanged.
- Accept with cmd_load = 0:
  - ALU_option <= cmd_op and ALU_in1 <= rf[cmd_src1].
  - ALU_in2 <= cmd_use_imm ? cmd_imm : rf[cmd_src2].
  - cmd_dst is latched; FSM goes to EXEC.
- EXEC lasts exactly one cycle. On the edge that ends it:
  - rf[dst] <= ALU_out, and res_data/res_dst are updated.
  - res_valid = 1 in the next cycle; FSM returns to IDLE.
- res_zero is combinational from res_data. res_data and res_dst hold their values until the next write.
- All arithmetic is done by the ALU. Results are WIDTH bits with wrap-around; no carry or overflow is reported.
- ALU_* outputs hold their last values in IDLE, so the ALU inputs stay stable.
- Operands are read at the accept edge. A write from the previous command is already visible, so no hazard logic is needed.
- rd_data is a plain combinational read with no write bypass; a new value appears after the write edge.
- cmd_* inputs are sampled only at the accept edge. Changes while cmd_ready = 0 are ignored.

## Timing
- Reset, effective at the rising edge with reset = 1:
  - state = IDLE, all rf entries = 0.
  - ALU_option = 0, ALU_in1 = 0, ALU_in2 = 0.
  - res_valid = 0, res_data = 0, res_dst = 0, so res_zero = 1.
  - cmd_ready = 0 while reset is high; it is 1 in the first cycle after reset deasserts.
- Reset in EXEC aborts the command: no rf write and no res_valid.
- ALU command: accept at edge N, ALU inputs valid in cycle N, rf written at edge N+1, res_valid high in cycle N+1. Throughput is one ALU command per 2 cycles.
- Load command: rf written at edge N, res_valid high in cycle N; back-to-back loads at 1 per cycle.
- A load and an ALU command can be accepted on consecutive edges.

## Test plan
- After reset: load r1=5, load r2=3, then op=000 dst=0 src1=1 src2=2 -> ALU_in1=5, ALU_in2=3; one cycle later res_valid=1, res_data=8, res_dst=0, res_zero=0, rd_data(rd_addr=0)=8.
- r1=3, r2=3, op=001 -> res_data=0, res_zero=1.
- Wrap-around: r1=12, imm=7, use_imm=1, op=000 -> res_data=3.
- Immediate logic: r3=0xF, op=010, imm=0xA, use_imm=1, dst=3 -> rf[3]=0xA.
- Back-pressure: hold cmd_valid=1 for 4 cycles with ALU commands -> cmd_ready alternates 1,0,1,0; exactly 2 commands accepted; res_valid pulses twice.
- Reset asserted during EXEC of op=000 r0=r1+r2 -> no res_valid, rf[0]=0, cmd_ready=1 in the first cycle after reset deasserts.

Source files
------------

// File: rtl/alu4_sequencer.sv
// ============================================================================
//  Module   : alu4_sequencer
//  Brief    : Command-driven operand sequencer and register file in front of
//             a combinational ALU; reports each written result with a strobe.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module alu4_sequencer #(
   parameter int WIDTH  = 4,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [2:0]        cmd_op,
   input  logic [ADDR_W-1:0] cmd_dst,
   input  logic [ADDR_W-1:0] cmd_src1,
   input  logic [ADDR_W-1:0] cmd_src2,
   input  logic [WIDTH-1:0]  cmd_imm,
   input  logic              cmd_use_imm,
   input  logic              cmd_load,
   output logic [2:0]        ALU_option,
   output logic [WIDTH-1:0]  ALU_in1,
   output logic [WIDTH-1:0]  ALU_in2,
   input  logic [WIDTH-1:0]  ALU_out,
   output logic              res_valid,
   output logic [WIDTH-1:0]  res_data,
   output logic [ADDR_W-1:0] res_dst,
   output logic              res_zero,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WIDTH-1:0]  rd_data
);

   localparam int NREG = 2 ** ADDR_W;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EXEC = 1'b1
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic [WIDTH-1:0]  rf_q [NREG];
   logic [2:0]        alu_op_q;
   logic [WIDTH-1:0]  alu_in1_q;
   logic [WIDTH-1:0]  alu_in2_q;
   logic [ADDR_W-1:0] dst_q;
   logic              res_valid_q;
   logic [WIDTH-1:0]  res_data_q;
   logic [ADDR_W-1:0] res_dst_q;

   logic              load_acc;
   logic              alu_acc;
   logic              exec_wr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cmd_ready = 1'b0;
      load_acc  = 1'b0;
      alu_acc   = 1'b0;
      exec_wr   = 1'b0;
      case (state_q)
         IDLE: begin
            cmd_ready = !reset;
            if (cmd_valid && cmd_ready) begin
               if (cmd_load) begin
                  load_acc = 1'b1;
               end else begin
                  alu_acc = 1'b1;
                  state_d = EXEC;
               end
            end
         end
         EXEC: begin
            exec_wr = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Reset takes priority over exec_wr, so a command caught in EXEC is dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         alu_op_q    <= '0;
         alu_in1_q   <= '0;
         alu_in2_q   <= '0;
         dst_q       <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_dst_q   <= '0;
         for (int i = 0; i < NREG; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         res_valid_q <= load_acc | exec_wr;
         if (load_acc) begin
            rf_q[cmd_dst] <= cmd_imm;
            res_data_q    <= cmd_imm;
            res_dst_q     <= cmd_dst;
         end
         if (alu_acc) begin
            alu_op_q  <= cmd_op;
            alu_in1_q <= rf_q[cmd_src1];
            alu_in2_q <= cmd_use_imm ? cmd_imm : rf_q[cmd_src2];
            dst_q     <= cmd_dst;
         end
         if (exec_wr) begin
            rf_q[dst_q] <= ALU_out;
            res_data_q  <= ALU_out;
            res_dst_q   <= dst_q;
         end
      end
   end

   assign ALU_option = alu_op_q;
   assign ALU_in1    = alu_in1_q;
   assign ALU_in2    = alu_in2_q;
   assign res_valid  = res_valid_q;
   assign res_data   = res_data_q;
   assign res_dst    = res_dst_q;
   assign res_zero   = (res_data_q == '0);
   assign rd_data    = rf_q[rd_addr];

endmodule

`default_nettype wire

// File: tb/tb_alu4_sequencer.sv
// ============================================================================
//  Module   : tb_alu4_sequencer
//  Brief    : Directed self-checking bench with a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu4_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [1:0] cmd_dst;
   logic [1:0] cmd_src1;
   logic [1:0] cmd_src2;
   logic [3:0] cmd_imm;
   logic       cmd_use_imm;
   logic       cmd_load;
   logic [2:0] ALU_option;
   logic [3:0] ALU_in1;
   logic [3:0] ALU_in2;
   logic [3:0] ALU_out;
   logic       res_valid;
   logic [3:0] res_data;
   logic [1:0] res_dst;
   logic       res_zero;
   logic [1:0] rd_addr;
   logic [3:0] rd_data;

   logic       rd_force_en = 1'b0;
   logic [1:0] rd_force    = 2'd0;
   logic [7:0] cyc         = 8'd0;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   alu4_sequencer #(.WIDTH(4), .ADDR_W(2)) dut (
      .clk         (clk),
      .reset       (reset),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_op      (cmd_op),
      .cmd_dst     (cmd_dst),
      .cmd_src1    (cmd_src1),
      .cmd_src2    (cmd_src2),
      .cmd_imm     (cmd_imm),
      .cmd_use_imm (cmd_use_imm),
      .cmd_load    (cmd_load),
      .ALU_option  (ALU_option),
      .ALU_in1     (ALU_in1),
      .ALU_in2     (ALU_in2),
      .ALU_out     (ALU_out),
      .res_valid   (res_valid),
      .res_data    (res_data),
      .res_dst     (res_dst),
      .res_zero    (res_zero),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data)
   );

   // Stand-in for the downstream combinational ALU.
   function automatic logic [3:0] alu_fn(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ~a;
         3'd6:    return a << 1;
         default: return b;
      endcase
   endfunction

   assign ALU_out = alu_fn(ALU_option, ALU_in1, ALU_in2);
   assign rd_addr = rd_force_en ? rd_force : cyc[1:0];

   always @(posedge clk) cyc <= cyc + 8'd1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Transaction-level model: register file, one outstanding ALU result.
   logic [3:0] m_rf [4];
   bit         m_init    = 1'b0;
   bit         m_pending = 1'b0;
   logic [1:0] m_pdst;
   logic [3:0] m_pres;
   logic [2:0] m_op;
   logic [3:0] m_in1;
   logic [3:0] m_in2;
   bit         m_rv;
   logic [3:0] m_rdata;
   logic [1:0] m_rdst;

   always @(posedge clk) begin
      if (reset) begin
         m_init    = 1'b1;
         m_pending = 1'b0;
         for (int i = 0; i < 4; i++) m_rf[i] = 4'd0;
         m_op = 3'd0; m_in1 = 4'd0; m_in2 = 4'd0;
         m_rv = 1'b0; m_rdata = 4'd0; m_rdst = 2'd0;
      end else if (m_init) begin
         m_rv = 1'b0;
         if (m_pending) begin
            m_rf[m_pdst] = m_pres;
            m_rdata      = m_pres;
            m_rdst       = m_pdst;
            m_rv         = 1'b1;
            m_pending    = 1'b0;
         end else if (cmd_valid) begin
            if (cmd_load) begin
               m_rf[cmd_dst] = cmd_imm;
               m_rdata       = cmd_imm;
               m_rdst        = cmd_dst;
               m_rv          = 1'b1;
            end else begin
               m_op      = cmd_op;
               m_in1     = m_rf[cmd_src1];
               m_in2     = cmd_use_imm ? cmd_imm : m_rf[cmd_src2];
               m_pres    = alu_fn(m_op, m_in1, m_in2);
               m_pdst    = cmd_dst;
               m_pending = 1'b1;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_init) begin
         chk("cmd_ready",  cmd_ready,  !reset && !m_pending);
         chk("res_valid",  res_valid,  m_rv);
         chk("res_data",   res_data,   m_rdata);
         chk("res_dst",    res_dst,    m_rdst);
         chk("res_zero",   res_zero,   m_rdata == 4'd0);
         chk("ALU_option", ALU_option, m_op);
         chk("ALU_in1",    ALU_in1,    m_in1);
         chk("ALU_in2",    ALU_in2,    m_in2);
         chk("rd_data",    rd_data,    m_rf[rd_addr]);
      end
   end

   task automatic next_cyc();
      @(posedge clk);
      #2;
   endtask

   task automatic rd_chk(input string name, input logic [1:0] a, input logic [3:0] exp);
      rd_force    = a;
      rd_force_en = 1'b1;
      #1;
      chk(name, rd_data, exp);
      rd_force_en = 1'b0;
   endtask

   // Presents a command and returns just after the edge that accepted it.
   task automatic send(input logic ld, input logic [2:0] op, input logic [1:0] dst,
                       input logic [1:0] s1, input logic [1:0] s2,
                       input logic [3:0] imm, input logic ui);
      bit ok;
      ok          = 1'b0;
      cmd_load    = ld;
      cmd_op      = op;
      cmd_dst     = dst;
      cmd_src1    = s1;
      cmd_src2    = s2;
      cmd_imm     = imm;
      cmd_use_imm = ui;
      cmd_valid   = 1'b1;
      for (int w = 0; w < 10 && !ok; w++) begin
         @(negedge clk);
         ok = cmd_ready;
         @(posedge clk);
         #2;
      end
      cmd_valid = 1'b0;
      chk("accept_in_time", ok, 1'b1);
   endtask

   task automatic load(input logic [1:0] dst, input logic [3:0] imm);
      send(1'b1, 3'd0, dst, 2'd0, 2'd0, imm, 1'b0);
   endtask

   initial begin
      bit [3:0] pat;
      int       acc;
      int       rv;
      reset = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_dst = 2'd0;
      cmd_src1 = 2'd0; cmd_src2 = 2'd0; cmd_imm = 4'd0; cmd_use_imm = 1'b0; cmd_load = 1'b0;
      repeat (3) next_cyc();
      chk("rst_cmd_ready", cmd_ready, 1'b0);
      chk("rst_res_zero",  res_zero,  1'b1);
      chk("rst_res_valid", res_valid, 1'b0);
      chk("rst_alu_in1",   ALU_in1,   4'd0);
      reset = 1'b0;
      #1;
      chk("post_rst_ready", cmd_ready, 1'b1);

      // 5 + 3
      load(2'd1, 4'd5);
      load(2'd2, 4'd3);
      send(1'b0, 3'd0, 2'd0, 2'd1, 2'd2, 4'd0, 1'b0);
      chk("add_in1", ALU_in1, 4'd5);
      chk("add_in2", ALU_in2, 4'd3);
      next_cyc();
      chk("add_valid", res_valid, 1'b1);
      chk("add_data",  res_data,  4'd8);
      chk("add_dst",   res_dst,   2'd0);
      chk("add_zero",  res_zero,  1'b0);
      rd_chk("add_rd0", 2'd0, 4'd8);

      // 3 - 3 -> zero flag
      load(2'd1, 4'd3);
      load(2'd2, 4'd3);
      send(1'b0, 3'd1, 2'd0, 2'd1, 2'd2, 4'd0, 1'b0);
      next_cyc();
      chk("sub_data", res_data, 4'd0);
      chk("sub_zero", res_zero, 1'b1);

      // 12 + 7 wraps to 3
      load(2'd1, 4'd12);
      send(1'b0, 3'd0, 2'd2, 2'd1, 2'd0, 4'd7, 1'b1);
      next_cyc();
      chk("wrap_data", res_data, 4'd3);
      chk("wrap_dst",  res_dst,  2'd2);

      // 0xF & 0xA
      load(2'd3, 4'hF);
      send(1'b0, 3'd2, 2'd3, 2'd3, 2'd0, 4'hA, 1'b1);
      next_cyc();
      chk("and_data", res_data, 4'hA);
      rd_chk("and_rd3", 2'd3, 4'hA);
      next_cyc();

      // Back-pressure: valid held for 4 cycles
      pat = 4'd0; acc = 0; rv = 0;
      cmd_load = 1'b0; cmd_op = 3'd0; cmd_dst = 2'd1; cmd_src1 = 2'd1;
      cmd_src2 = 2'd2; cmd_use_imm = 1'b0; cmd_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         pat = {pat[2:0], cmd_ready};
         if (cmd_ready) acc++;
         if (res_valid) rv++;
         next_cyc();
      end
      cmd_valid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         if (res_valid) rv++;
         next_cyc();
      end
      chk("bp_ready_pattern", pat, 4'b1010);
      chk("bp_accepts",       acc, 2);
      chk("bp_res_pulses",    rv,  2);
      rd_chk("bp_rd1", 2'd1, 4'd2);

      // Reset during EXEC aborts the command
      load(2'd0, 4'd9);
      load(2'd1, 4'd1);
      load(2'd2, 4'd2);
      send(1'b0, 3'd0, 2'd0, 2'd1, 2'd2, 4'd0, 1'b0);
      reset = 1'b1;
      next_cyc();
      reset = 1'b0;
      #1;
      chk("abort_ready", cmd_ready, 1'b1);
      chk("abort_valid", res_valid, 1'b0);
      rd_chk("abort_rd0", 2'd0, 4'd0);
      next_cyc();
      chk("abort_valid2", res_valid, 1'b0);
      rd_chk("abort_rd0b", 2'd0, 4'd0);

      next_cyc();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
